// File: rtl/ascii_overlay_render.sv
// ascii_overlay_render
//   Overlays up to 16 coloured 4-character strings onto a video raster.
//   Descriptors are shadowed once per frame, so text never tears mid-frame.
//   Glyph rows come from an external synchronous font ROM (one clock read).
//   Video latency is a fixed 4 clocks: S0 input reg, S1 hit/priority,
//   S2 ROM address, S3 ROM data, S4 output reg.
module ascii_overlay_render #(
   parameter int L_W         = 8,   // glyph cell width, 8 only
   parameter int L_H         = 16,  // glyph cell height
   parameter int COORD_SHIFT = 2    // descriptor coordinate to pixel shift
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic [1023:0]     i_str,
   input  logic              i_vs,
   input  logic              i_hs,
   input  logic              i_de,
   input  logic [11:0]       i_x,
   input  logic [11:0]       i_y,
   input  logic [23:0]       i_rgb,
   output logic [10:0]       o_font_addr,
   input  logic [L_W-1:0]    i_font_data,
   output logic              o_vs,
   output logic              o_hs,
   output logic              o_de,
   output logic [23:0]       o_rgb
);
   localparam int N_ENT = 16;
   localparam int COL_W = $clog2(L_W);
   localparam int ROW_W = $clog2(L_H);
   localparam int DX_W  = $clog2(4 * L_W);

   typedef struct packed {
      logic [2:0]  color;
      logic [7:0]  x;
      logic [7:0]  y;
      logic [31:0] chars;
   } desc_t;

   localparam int PAD_W = 64 - $bits(desc_t);

   typedef struct packed {
      logic        vs;
      logic        hs;
      logic        de;
      logic [23:0] rgb;
   } side_t;

   // Box end with saturation instead of wrap-around.
   function automatic logic [11:0] sat_end(input logic [11:0] base, input int span);
      logic [12:0] sum;
      sum = {1'b0, base} + 13'(span);
      return sum[12] ? 12'hFFF : sum[11:0];
   endfunction

   function automatic logic visible(input logic [7:0] c);
      return (c >= 8'd33) && (c <= 8'd126);
   endfunction

   desc_t               shadow [N_ENT];
   logic                vs_prev;
   logic [11:0]         s0_x, s0_y;
   side_t               s0_sd, s1_sd, s2_sd, s3_sd;
   logic [11:0]         x0 [N_ENT];
   logic [11:0]         y0 [N_ENT];
   logic [N_ENT-1:0]    hit_vec;
   logic [3:0]          sel;
   logic                hit_n;
   logic [DX_W-1:0]     dx;
   logic [1:0]          char_idx;
   logic [7:0]          char_n;
   logic [ROW_W-1:0]    row_n;
   logic                s1_hit;
   logic [7:0]          s1_char;
   logic [COL_W-1:0]    s1_col, s2_col, s3_col;
   logic [ROW_W-1:0]    s1_row;
   logic [2:0]          s1_color, s2_color, s3_color;
   logic                s2_lit_en, s3_lit_en;
   logic                lit;
   logic [N_ENT*PAD_W-1:0] unused_hi_bits;

   // Descriptor bits above the colour field carry nothing for this block.
   always_comb begin
      for (int k = 0; k < N_ENT; k++) unused_hi_bits[k*PAD_W +: PAD_W] = i_str[k*64+$bits(desc_t) +: PAD_W];
   end

   // S0: register pixel position and sideband; remember previous vs for edge detect.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         s0_x    <= '0;
         s0_y    <= '0;
         s0_sd   <= '0;
         vs_prev <= 1'b0;
      end else begin
         // NOTE: sequential state uses <= so every flop samples pre-edge values.
         s0_x    <= i_x;
         s0_y    <= i_y;
         s0_sd   <= '{vs: i_vs, hs: i_hs, de: i_de, rgb: i_rgb};
         vs_prev <= s0_sd.vs;
      end
   end

   // Shadow reload one clock after the vs rise reaches S0, so the rising-edge pixel still sees the old set.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         // NOTE: the shadow is plain flops, not RAM; clearing it is what blanks the overlay after reset.
         for (int k = 0; k < N_ENT; k++) shadow[k] <= '0;
      end else if (s0_sd.vs && !vs_prev) begin
         for (int k = 0; k < N_ENT; k++) shadow[k] <= desc_t'(i_str[k*64 +: $bits(desc_t)]);
      end
   end

   // S1a: 16 parallel box tests against the shadow.
   always_comb begin
      for (int k = 0; k < N_ENT; k++) begin
         x0[k]      = 12'(shadow[k].x) << COORD_SHIFT;
         y0[k]      = 12'(shadow[k].y) << COORD_SHIFT;
         hit_vec[k] = (s0_x >= x0[k]) && (s0_x < sat_end(x0[k], 4 * L_W)) &&
                      (s0_y >= y0[k]) && (s0_y < sat_end(y0[k], L_H));
      end
   end

   // S1b: priority encode, lowest index wins overlapping boxes.
   always_comb begin
      // NOTE: defaults first so every path assigns and no latch is inferred.
      sel   = '0;
      hit_n = 1'b0;
      for (int k = N_ENT - 1; k >= 0; k--) begin
         if (hit_vec[k]) begin
            sel   = 4'(k);
            hit_n = 1'b1;
         end
      end
   end

   // S1c: offset inside the winning box selects character, column and glyph row.
   always_comb begin
      dx       = s0_x[DX_W-1:0] - x0[sel][DX_W-1:0];
      char_idx = dx[DX_W-1 -: 2];
      char_n   = 8'(shadow[sel].chars >> {~char_idx, 3'b000});
      row_n    = s0_y[ROW_W-1:0] - y0[sel][ROW_W-1:0];
   end

   // S1 register: hit result and sideband.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         s1_hit   <= 1'b0;
         s1_char  <= '0;
         s1_col   <= '0;
         s1_row   <= '0;
         s1_color <= '0;
         s1_sd    <= '0;
      end else begin
         s1_hit   <= hit_n;
         s1_char  <= char_n;
         s1_col   <= dx[COL_W-1:0];
         s1_row   <= row_n;
         s1_color <= shadow[sel].color;
         s1_sd    <= s0_sd;
      end
   end

   // S2: issue the font ROM address; transparent codes are pre-masked here.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         o_font_addr <= '0;
         s2_lit_en   <= 1'b0;
         s2_col      <= '0;
         s2_color    <= '0;
         s2_sd       <= '0;
      end else begin
         o_font_addr <= {s1_char[6:0], s1_row};
         s2_lit_en   <= s1_hit && visible(s1_char);
         s2_col      <= s1_col;
         s2_color    <= s1_color;
         s2_sd       <= s1_sd;
      end
   end

   // S3: wait stage aligned with the ROM read.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         s3_lit_en <= 1'b0;
         s3_col    <= '0;
         s3_color  <= '0;
         s3_sd     <= '0;
      end else begin
         s3_lit_en <= s2_lit_en;
         s3_col    <= s2_col;
         s3_color  <= s2_color;
         s3_sd     <= s2_sd;
      end
   end

   // Glyph bit 7 is the leftmost pixel of the cell.
   assign lit = s3_lit_en && i_font_data[COL_W'(L_W - 1) - s3_col];

   // S4: output register; blank outside the active area.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         o_vs  <= 1'b0;
         o_hs  <= 1'b0;
         o_de  <= 1'b0;
         o_rgb <= '0;
      end else begin
         o_vs <= s3_sd.vs;
         o_hs <= s3_sd.hs;
         o_de <= s3_sd.de;
         if (!s3_sd.de)
            o_rgb <= '0;
         else if (lit)
            o_rgb <= {{8{s3_color[2]}}, {8{s3_color[1]}}, {8{s3_color[0]}}};
         else
            o_rgb <= s3_sd.rgb;
      end
   end

endmodule

// File: tb/tb_ascii_overlay_render.sv
// Testbench for ascii_overlay_render: directed table, hand sequences for
// shadow timing and reset, and random raster traffic against a pixel model.
module tb_ascii_overlay_render;
   localparam logic [23:0] BG = 24'h123456;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [1023:0] str = '0;
   logic          vs = 1'b0, hs = 1'b0, de = 1'b0;
   logic [11:0]   x = '0, y = '0;
   logic [23:0]   rgb = '0;
   logic [10:0]   o_font_addr;
   logic [7:0]    font_data = '0;
   logic          o_vs, o_hs, o_de;
   logic [23:0]   o_rgb;
   bit            rom_mode = 1'b1;

   int n_checks = 0;
   int n_errors = 0;

   logic [63:0]   m_shadow [16];
   bit            m_pending, m_prev_vs;
   logic [31:0]   exp_q[$];
   string         tag_q[$];

   typedef struct {
      int          cfg;
      int          px;
      int          py;
      bit          pde;
      logic [23:0] exp_rgb;
   } vec_t;
   vec_t tab[$];

   ascii_overlay_render dut (
      .sys_clk     (clk),
      .sys_rst_n   (rst_n),
      .i_str       (str),
      .i_vs        (vs),
      .i_hs        (hs),
      .i_de        (de),
      .i_x         (x),
      .i_y         (y),
      .i_rgb       (rgb),
      .o_font_addr (o_font_addr),
      .i_font_data (font_data),
      .o_vs        (o_vs),
      .o_hs        (o_hs),
      .o_de        (o_de),
      .o_rgb       (o_rgb)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] glyph(input int ch, input int row);
      return 8'((ch * 37) ^ (row * 11) ^ (ch >> 2));
   endfunction

   // Synchronous font ROM: data one clock after the address.
   always @(posedge clk) font_data <= rom_mode ? 8'h80 : glyph(int'(o_font_addr[10:4]), int'(o_font_addr[3:0]));

   // Reference pixel: first box (lowest index) containing the pixel decides.
   function automatic logic [23:0] model_rgb(input int px, input int py, input logic [23:0] bg, input bit pde);
      logic [63:0] d;
      int x0, y0, xe, ye, dx, ch, col, row;
      logic [7:0] g;
      if (!pde) return 24'h0;
      for (int k = 0; k < 16; k++) begin
         d  = m_shadow[k];
         x0 = int'(d[47:40]) * 4;
         y0 = int'(d[39:32]) * 4;
         xe = (x0 + 32 > 4095) ? 4095 : x0 + 32;
         ye = (y0 + 16 > 4095) ? 4095 : y0 + 16;
         if (px >= x0 && px < xe && py >= y0 && py < ye) begin
            dx  = px - x0;
            ch  = int'((d[31:0] >> (24 - 8 * (dx / 8))) & 32'hFF);
            col = dx % 8;
            row = py - y0;
            g   = rom_mode ? 8'h80 : glyph(ch, row);
            if (ch >= 33 && ch <= 126 && g[7 - col])
               return {{8{d[50]}}, {8{d[49]}}, {8{d[48]}}};
            return bg;
         end
      end
      return bg;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic reset_model();
      for (int k = 0; k < 16; k++) m_shadow[k] = '0;
      m_pending = 1'b0;
      m_prev_vs = 1'b0;
      exp_q.delete();
      tag_q.delete();
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back('0);
         tag_q.push_back("flush");
      end
   endtask

   // One pixel clock: apply inputs, queue the expectation, check the pixel from 4 clocks ago.
   task automatic drive(input int px, input int py, input logic [23:0] bg, input bit pde, input bit pvs,
                        input bit phs, input bit use_tab, input logic [23:0] tab_rgb, input string tag);
      logic [23:0] e;
      if (m_pending)
         for (int k = 0; k < 16; k++) m_shadow[k] = str[k*64 +: 64];
      e = use_tab ? tab_rgb : model_rgb(px, py, bg, pde);
      m_pending = pvs && !m_prev_vs;
      m_prev_vs = pvs;
      x = 12'(px); y = 12'(py); rgb = bg; de = pde; vs = pvs; hs = phs;
      exp_q.push_back({5'b0, pvs, phs, pde, e});
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      check(tag_q.pop_front(), {5'b0, o_vs, o_hs, o_de, o_rgb}, exp_q.pop_front());
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0, "idle");
   endtask

   task automatic vsync();
      drive(0, 0, 24'h0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0, "vsync");
      drive(0, 0, 24'h0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0, "vsync");
      idle(2);
   endtask

   task automatic set_entry(input int k, input logic [2:0] c, input logic [7:0] ex, input logic [7:0] ey,
                            input logic [31:0] ch);
      str[k*64 +: 64] = {13'h1ABC, c, ex, ey, ch};
   endtask

   task automatic load_cfg(input int cfg);
      idle(4);
      rom_mode = 1'b1;
      str = '0;
      if (cfg == 0) begin
         set_entry(0, 3'b001, 8'd50, 8'd135, 32'h20303432);
      end else begin
         set_entry(0, 3'b100, 8'd10, 8'd10, 32'h41414141);
         set_entry(3, 3'b010, 8'd10, 8'd10, 32'h42424242);
         set_entry(5, 3'b111, 8'd255, 8'd255, 32'h5758595A);
      end
      vsync();
   endtask

   task automatic rand_entry(input int k);
      str[k*64 +: 64] = {13'($urandom), 3'($urandom), 8'($urandom_range(0, 40)), 8'($urandom_range(0, 40)),
                         8'($urandom_range(28, 132)), 8'($urandom_range(28, 132)),
                         8'($urandom_range(28, 132)), 8'($urandom_range(28, 132))};
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int cur_cfg;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_vs", 32'(o_vs), 32'h0);
      check("rst_hs", 32'(o_hs), 32'h0);
      check("rst_de", 32'(o_de), 32'h0);
      check("rst_rgb", 32'(o_rgb), 32'h0);
      check("rst_font_addr", 32'(o_font_addr), 32'h0);
      rst_n = 1'b1;
      reset_model();

      // Empty descriptors: background passes with exactly 4 clocks latency
      vsync();
      for (int i = 0; i < 150; i++)
         drive(100 + i % 64, i / 64, BG, 1'b1, 1'b0, 1'(i % 64 == 63), 1'b1, BG, "bg_pass");

      // Directed table
      tab.push_back('{0, 200, 540, 1'b1, BG});
      tab.push_back('{0, 207, 540, 1'b1, BG});
      tab.push_back('{0, 208, 540, 1'b1, 24'h0000FF});
      tab.push_back('{0, 209, 540, 1'b1, BG});
      tab.push_back('{0, 216, 540, 1'b1, 24'h0000FF});
      tab.push_back('{0, 224, 540, 1'b1, 24'h0000FF});
      tab.push_back('{0, 231, 540, 1'b1, BG});
      tab.push_back('{0, 232, 540, 1'b1, BG});
      tab.push_back('{0, 199, 540, 1'b1, BG});
      tab.push_back('{0, 216, 555, 1'b1, 24'h0000FF});
      tab.push_back('{0, 216, 556, 1'b1, BG});
      tab.push_back('{0, 216, 539, 1'b1, BG});
      tab.push_back('{0, 216, 540, 1'b0, 24'h000000});
      tab.push_back('{1, 40, 40, 1'b1, 24'hFF0000});
      tab.push_back('{1, 41, 40, 1'b1, BG});
      tab.push_back('{1, 64, 55, 1'b1, 24'hFF0000});
      tab.push_back('{1, 71, 55, 1'b1, BG});
      tab.push_back('{1, 72, 40, 1'b1, BG});
      tab.push_back('{1, 1020, 1020, 1'b1, 24'hFFFFFF});
      tab.push_back('{1, 1044, 1035, 1'b1, 24'hFFFFFF});
      tab.push_back('{1, 1051, 1020, 1'b1, BG});
      tab.push_back('{1, 1052, 1020, 1'b1, BG});
      tab.push_back('{1, 1020, 1036, 1'b1, BG});
      tab.push_back('{1, 0, 1020, 1'b1, BG});
      tab.push_back('{1, 28, 1020, 1'b1, BG});
      cur_cfg = -1;
      foreach (tab[i]) begin
         if (tab[i].cfg != cur_cfg) begin
            load_cfg(tab[i].cfg);
            cur_cfg = tab[i].cfg;
         end
         drive(tab[i].px, tab[i].py, BG, tab[i].pde, 1'b0, 1'b0, 1'b1, tab[i].exp_rgb, $sformatf("tab%0d", i));
      end

      // Mid-frame descriptor change is held off until the next vs rise
      load_cfg(0);
      set_entry(0, 3'b010, 8'd50, 8'd135, 32'h20303432);
      drive(216, 540, BG, 1'b1, 1'b0, 1'b0, 1'b1, 24'h0000FF, "midframe_old");
      drive(224, 540, BG, 1'b1, 1'b0, 1'b0, 1'b1, 24'h0000FF, "midframe_old");
      vsync();
      drive(216, 540, BG, 1'b1, 1'b0, 1'b0, 1'b1, 24'h00FF00, "nextframe_new");

      // Pixel coincident with the vs rise uses the old shadow, the next one the new
      set_entry(0, 3'b001, 8'd50, 8'd135, 32'h20303432);
      drive(216, 540, BG, 1'b1, 1'b1, 1'b0, 1'b1, 24'h00FF00, "vs_edge_old");
      drive(216, 540, BG, 1'b1, 1'b1, 1'b0, 1'b1, 24'h0000FF, "vs_edge_new");
      drive(216, 540, BG, 1'b1, 1'b0, 1'b0, 1'b1, 24'h0000FF, "vs_edge_new");

      // Asynchronous reset mid-line
      drive(216, 540, BG, 1'b1, 1'b0, 1'b1, 1'b1, 24'h0000FF, "pre_reset");
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_vs", 32'(o_vs), 32'h0);
      check("async_rst_hs", 32'(o_hs), 32'h0);
      check("async_rst_de", 32'(o_de), 32'h0);
      check("async_rst_rgb", 32'(o_rgb), 32'h0);
      check("async_rst_font_addr", 32'(o_font_addr), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      reset_model();
      drive(216, 540, BG, 1'b1, 1'b0, 1'b0, 1'b1, BG, "post_rst_no_overlay");
      drive(224, 540, BG, 1'b1, 1'b0, 1'b0, 1'b1, BG, "post_rst_no_overlay");
      idle(4);
      vsync();
      drive(216, 540, BG, 1'b1, 1'b0, 1'b0, 1'b1, 24'h0000FF, "post_rst_vs_overlay");

      // Random raster traffic against the model
      idle(4);
      rom_mode = 1'b0;
      for (int k = 0; k < 16; k++) rand_entry(k);
      vsync();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) rand_entry(int'($urandom_range(0, 15)));
         drive(int'($urandom_range(0, 200)), int'($urandom_range(0, 200)), 24'($urandom),
               1'($urandom_range(0, 3) != 0), 1'((i % 400) < 3), 1'($urandom_range(0, 1)),
               1'b0, 24'h0, "rand");
      end
      idle(4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
